// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, SPI mode and default geometry for spi_master.
package spi_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_e;
   localparam logic [1:0] SPI_MODE = 2'b00;
   localparam int DEF_CLK_DIV = 4;
   localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SCLK divider; the tick that ends each half-period is a rise or fall strobe by current level.
module spi_sclk_gen import spi_pkg::*; #(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic rise,
   output logic fall,
   output logic sclk
);
   logic [7:0] cnt_q, cnt_d;
   logic       lvl_q, lvl_d, tick;
   always_comb begin
      tick = en && cnt_q == 8'(CLK_DIV - 1);
      rise = tick && !lvl_q;
      fall = tick && lvl_q;
      cnt_d = (!en || clr || tick) ? '0 : cnt_q + 8'd1;
      lvl_d = (!en || clr) ? SPI_MODE[1] : lvl_q ^ tick;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         lvl_q <= SPI_MODE[1];
      end else begin
         cnt_q <= cnt_d;
         lvl_q <= lvl_d;
      end
   end
   assign sclk = lvl_q;
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, one DATA_W-bit full-duplex transfer per accepted request.
module spi_master import spi_pkg::*; #(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);
   localparam int BW = $clog2(DATA_W + 1);
   state_e            state_q, state_d;
   logic [DATA_W-1:0] sh_q, sh_d, rx_q, rx_d;
   logic [BW-1:0]     nfall_q, nfall_d;
   logic              samp_q, samp_d, mosi_q, mosi_d, cs_n_q, cs_n_d, rxv_q, rxv_d;
   logic              en, rise, fall, last, fin;
   assign en = state_q == SETUP || state_q == XFER;
   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_gen (
      .clk(clk), .rst(rst), .en(en), .clr(fin), .rise(rise), .fall(fall), .sclk(sclk)
   );
   // The rise strobe after the final low half-period ends the transfer instead of raising sclk;
   // miso is staged in samp_q so the untransmitted LSBs of sh_q survive until shifted out.
   always_comb begin
      last = nfall_q == BW'(DATA_W - 1);
      fin = state_q == XFER && rise && nfall_q == BW'(DATA_W);
      state_d = state_q;
      sh_d = sh_q;
      rx_d = rx_q;
      nfall_d = nfall_q;
      samp_d = (rise && !fin) ? miso : samp_q;
      mosi_d = mosi_q;
      cs_n_d = cs_n_q;
      rxv_d = 1'b0;
      case (state_q)
         IDLE: if (tx_valid) begin
            sh_d = tx_data;
            mosi_d = tx_data[DATA_W-1];
            cs_n_d = 1'b0;
            nfall_d = '0;
            state_d = SETUP;
         end
         SETUP: state_d = rise ? XFER : SETUP;
         XFER: begin
            nfall_d = fall ? nfall_q + 1'b1 : nfall_q;
            sh_d = (fall && !last) ? {sh_q[DATA_W-2:0], samp_q} : sh_q;
            mosi_d = (fall && !last) ? sh_q[DATA_W-2] : mosi_q;
            if (fin) begin
               rx_d = {sh_q[DATA_W-2:0], samp_q};
               rxv_d = 1'b1;
               cs_n_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         rx_q    <= '0;
         nfall_q <= '0;
         samp_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         rxv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         nfall_q <= nfall_d;
         samp_q  <= samp_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         rxv_q   <= rxv_d;
      end
   end
   assign tx_ready = state_q == IDLE;
   assign rx_data  = rx_q;
   assign rx_valid = rxv_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;
endmodule
